// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake movement sequencer: game states,
// one-hot heading constants and the reverse-heading test.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } game_state_t;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_UP    = 4'b1000;
  localparam dir_t DIR_DOWN  = 4'b0100;
  localparam dir_t DIR_RIGHT = 4'b0010;
  localparam dir_t DIR_LEFT  = 4'b0001;

  function automatic logic is_reverse(dir_t a, dir_t b);
    return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP))    ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT))  ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT));
  endfunction

endpackage

// File: rtl/snake_move_sequencer_if.sv
// Bundle between the keypad/collision side and the sequencer; master drives the
// requests and observes the step/heading/game outputs, slave is the sequencer.
interface snake_move_sequencer_if;
  import snake_pkg::*;

  logic        start;
  logic        pause;
  logic        up;
  logic        down;
  logic        right;
  logic        left;
  logic        collision;
  logic        step_tick;
  logic        cell_done;
  dir_t        direction;
  logic [1:0]  state;
  logic        endgame;

  modport master (
    output start, pause, up, down, right, left, collision,
    input  step_tick, cell_done, direction, state, endgame
  );

  modport slave (
    input  start, pause, up, down, right, left, collision,
    output step_tick, cell_done, direction, state, endgame
  );

endinterface

// File: rtl/snake_turn_fifo.sv
// Small synchronous queue of pending headings; exposes both head (next to apply)
// and tail (newest request). Push when full and pop when empty are ignored.
module snake_turn_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic push_i,
  input  dir_t push_dat_i,
  input  logic pop_i,
  output logic empty_o,
  output logic full_o,
  output dir_t head_o,
  output dir_t tail_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  dir_t             mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == FULL_CNT);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign tail_ptr = (wr_ptr_q == '0) ? LAST_PTR : (wr_ptr_q - 1'b1);
  assign head_o   = mem_q[rd_ptr_q];
  assign tail_o   = mem_q[tail_ptr];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : (wr_ptr_q + 1'b1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : (rd_ptr_q + 1'b1);
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible while cnt_q says they are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/snake_move_sequencer.sv
// Game FSM, step/cell tick generation and grid-aligned turn application for the
// snake position datapath; step_tick/cell_done are combinational, heading updates one cycle after cell_done.
module snake_move_sequencer
  import snake_pkg::*;
#(
  parameter int TICK_DIV       = 125_000,
  parameter int STEPS_PER_CELL = 32,
  parameter int QDEPTH         = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  snake_move_sequencer_if.slave  bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = (STEPS_PER_CELL > 1) ? $clog2(STEPS_PER_CELL) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_CELL - 1);

  game_state_t        state_q, state_d;
  dir_t               dir_q, dir_d;
  logic               endgame_q;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic               start_q, pause_q;
  logic [3:0]         keys_q;

  logic [3:0]         keys;
  logic [3:0]         key_rise;
  logic               start_rise, pause_rise;
  logic               step_tick, cell_done;
  logic               cand_vld;
  dir_t               cand_dir;
  dir_t               ref_dir;
  logic               turn_ok;
  logic               q_push, q_pop, q_flush;
  logic               q_empty, q_full;
  dir_t               q_head, q_tail;

  // Key bit order matches both the one-hot heading encoding and the priority.
  assign keys       = {bus.up, bus.down, bus.right, bus.left};
  assign key_rise   = keys & ~keys_q;
  assign start_rise = bus.start & ~start_q;
  assign pause_rise = bus.pause & ~pause_q;

  assign step_tick = !reset && (state_q == RUN) && (tick_cnt_q == TICK_LAST) && !bus.collision;
  assign cell_done = step_tick && (step_cnt_q == STEP_LAST);

  always_comb begin
    cand_vld = 1'b1;
    cand_dir = DIR_RIGHT;
    if (key_rise[3]) begin
      cand_dir = DIR_UP;
    end else if (key_rise[2]) begin
      cand_dir = DIR_DOWN;
    end else if (key_rise[1]) begin
      cand_dir = DIR_RIGHT;
    end else if (key_rise[0]) begin
      cand_dir = DIR_LEFT;
    end else begin
      cand_vld = 1'b0;
    end
  end

  // New turns are judged against the last heading we will have, not the current one.
  assign ref_dir = q_empty ? dir_q : q_tail;
  assign turn_ok = (cand_dir != ref_dir) && !is_reverse(cand_dir, ref_dir);
  assign q_push  = cand_vld && ((state_q == RUN) || (state_q == PAUSE)) && turn_ok && !q_full;
  assign q_pop   = cell_done && !q_empty;
  assign q_flush = (state_d == IDLE);

  snake_turn_fifo #(
    .DEPTH (QDEPTH)
  ) u_turn_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (q_flush),
    .push_i     (q_push),
    .push_dat_i (cand_dir),
    .pop_i      (q_pop),
    .empty_o    (q_empty),
    .full_o     (q_full),
    .head_o     (q_head),
    .tail_o     (q_tail)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_rise) state_d = RUN;
      end
      RUN: begin
        if (bus.collision)   state_d = OVER;
        else if (pause_rise) state_d = PAUSE;
      end
      PAUSE: begin
        if (pause_rise) state_d = RUN;
      end
      OVER: begin
        if (start_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    step_cnt_d = step_cnt_q;
    dir_d      = dir_q;
    if (state_q == RUN) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : (tick_cnt_q + 1'b1);
    end
    if (step_tick) begin
      step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : (step_cnt_q + 1'b1);
    end
    if (q_pop) begin
      dir_d = q_head;
    end
    // Entering (or sitting in) IDLE re-arms a fresh game.
    if (state_d == IDLE) begin
      tick_cnt_d = '0;
      step_cnt_d = '0;
      dir_d      = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_RIGHT;
      endgame_q  <= 1'b0;
      tick_cnt_q <= '0;
      step_cnt_q <= '0;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      keys_q     <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      endgame_q  <= (state_d == OVER);
      tick_cnt_q <= tick_cnt_d;
      step_cnt_q <= step_cnt_d;
      start_q    <= bus.start;
      pause_q    <= bus.pause;
      keys_q     <= keys;
    end
  end

  assign bus.step_tick = step_tick;
  assign bus.cell_done = cell_done;
  assign bus.direction = dir_q;
  assign bus.state     = state_q;
  assign bus.endgame   = endgame_q;

endmodule

// File: tb/tb_snake_move_sequencer.sv
// Randomized + directed bench: a cycle-level game model predicts every cycle's outputs
// and every step; a separate monitor pops and compares against the sequencer.
module tb_snake_move_sequencer;
  import snake_pkg::*;

  localparam int TD  = 4;
  localparam int SPC = 2;
  localparam int QD  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  snake_move_sequencer_if bus();

  snake_move_sequencer #(
    .TICK_DIV       (TD),
    .STEPS_PER_CELL (SPC),
    .QDEPTH         (QD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] dir;
    logic       eg;
    logic       stp;
  } cyc_exp_t;

  typedef struct packed {
    int         cyc;
    logic [3:0] dir;
    logic       cd;
  } step_exp_t;

  cyc_exp_t  cyc_q[$];
  step_exp_t step_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (game rules, plain ints/queues) ----------------
  int         m_state = 0;            // 0 idle, 1 run, 2 pause, 3 over
  logic [3:0] m_dir = 4'b0010;
  bit         m_end = 1'b0;
  int         m_tick = 0;
  int         m_step = 0;
  logic [3:0] m_q[$];
  bit         p_start = 1'b0;
  bit         p_pause = 1'b0;
  logic [3:0] p_keys = 4'b0000;

  function automatic bit opposite(input logic [3:0] a, input logic [3:0] b);
    bit a_vert, b_vert;
    a_vert = (a == 4'b1000) || (a == 4'b0100);
    b_vert = (b == 4'b1000) || (b == 4'b0100);
    return (a != b) && (a_vert == b_vert);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cyc_exp_t   e;
      step_exp_t  s;
      logic [3:0] keys, rise, cand, refd;
      bit         st, cd, full, accept, s_rise, p_rise;
      int         nxt;
      e.st  = 2'(m_state);
      e.dir = m_dir;
      e.eg  = m_end;
      if (reset) begin
        e.stp = 1'b0;
        cyc_q.push_back(e);
        m_state = 0; m_dir = 4'b0010; m_end = 1'b0; m_tick = 0; m_step = 0;
        m_q.delete();
        p_start = 1'b0; p_pause = 1'b0; p_keys = 4'b0000;
      end else begin
        keys   = {bus.up, bus.down, bus.right, bus.left};
        rise   = keys & ~p_keys;
        s_rise = bus.start && !p_start;
        p_rise = bus.pause && !p_pause;
        st = (m_state == 1) && (m_tick == TD - 1) && !bus.collision;
        cd = st && (m_step == SPC - 1);
        e.stp = st;
        cyc_q.push_back(e);
        if (st) begin
          s.cyc = cyc; s.dir = m_dir; s.cd = cd;
          step_q.push_back(s);
        end
        nxt = m_state;
        case (m_state)
          0: if (s_rise) nxt = 1;
          1: if (bus.collision) nxt = 3; else if (p_rise) nxt = 2;
          2: if (p_rise) nxt = 1;
          default: if (s_rise) nxt = 0;
        endcase
        cand = 4'b0000;
        if (rise[3])      cand = 4'b1000;
        else if (rise[2]) cand = 4'b0100;
        else if (rise[1]) cand = 4'b0010;
        else if (rise[0]) cand = 4'b0001;
        full   = (m_q.size() >= QD);
        refd   = (m_q.size() > 0) ? m_q[$] : m_dir;
        accept = ((m_state == 1) || (m_state == 2)) && (cand != 4'b0000) &&
                 (cand != refd) && !opposite(cand, refd) && !full;
        if (cd && (m_q.size() > 0)) m_dir = m_q.pop_front();
        if (accept) m_q.push_back(cand);
        if (m_state == 1) begin
          m_tick = (m_tick + 1) % TD;
          if (st) m_step = (m_step + 1) % SPC;
        end
        if (nxt == 0) begin
          m_q.delete(); m_dir = 4'b0010; m_tick = 0; m_step = 0;
        end
        m_end   = (nxt == 3);
        m_state = nxt;
        p_start = bus.start; p_pause = bus.pause; p_keys = keys;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      cyc_exp_t  e;
      step_exp_t s;
      if (cyc_q.size() == 0) begin
        chk("cycle_queue_underflow", 32'(cyc_q.size()), 32'd1);
      end else begin
        e = cyc_q.pop_front();
        chk("state",     32'(bus.state),     32'(e.st));
        chk("direction", 32'(bus.direction), 32'(e.dir));
        chk("endgame",   32'(bus.endgame),   32'(e.eg));
        chk("step_tick", 32'(bus.step_tick), 32'(e.stp));
      end
      if (bus.step_tick) begin
        if (step_q.size() == 0) begin
          chk("unexpected_step", 32'(bus.step_tick), 32'd0);
        end else begin
          s = step_q.pop_front();
          chk("step_cycle",     32'(cyc),           32'(s.cyc));
          chk("step_direction", 32'(bus.direction), 32'(s.dir));
          chk("cell_done",      32'(bus.cell_done), 32'(s.cd));
        end
      end else begin
        chk("cell_done_idle", 32'(bus.cell_done), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0; tick();
  endtask

  task automatic pulse_pause();
    bus.pause = 1'b1; tick(); bus.pause = 1'b0; tick();
  endtask

  task automatic press(input logic [3:0] k);
    {bus.up, bus.down, bus.right, bus.left} = k;
    tick();
    {bus.up, bus.down, bus.right, bus.left} = 4'b0000;
  endtask

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.collision = 1'b0;
    bus.up = 1'b0; bus.down = 1'b0; bus.right = 1'b0; bus.left = 1'b0;
    reset = 1'b1;
    idle(3);
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    idle(2);

    // plain running, heading right
    pulse_start();
    idle(20);
    // mid-cell turn up
    idle(2);
    press(4'b1000);
    idle(20);
    // fresh game heading right: left (reverse), up, down (reverse of tail), right
    reset = 1'b1; tick(); reset = 1'b0; tick();
    pulse_start();
    press(4'b0001);
    press(4'b1000);
    press(4'b0100);
    press(4'b0010);
    idle(24);
    // pause hold and resume
    idle(1);
    pulse_pause();
    idle(20);
    pulse_pause();
    idle(12);
    // collision exactly on a terminal tick count
    for (int i = 0; i < 16 && !((m_state == 1) && (m_tick == TD - 1)); i++) tick();
    bus.collision = 1'b1; tick(); bus.collision = 1'b0;
    idle(3);
    pulse_start();
    idle(3);
    // reset mid-cell with a queued turn
    pulse_start();
    idle(2);
    press(4'b1000);
    idle(1);
    reset = 1'b1; tick(); reset = 1'b0;
    idle(10);
    pulse_start();
    idle(10);

    // randomized play
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.up    = ($urandom_range(0, 5) == 0);
        bus.down  = ($urandom_range(0, 5) == 0);
        bus.right = ($urandom_range(0, 5) == 0);
        bus.left  = ($urandom_range(0, 5) == 0);
      end
      bus.collision = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) bus.pause = ~bus.pause;
      if ($urandom_range(0, 59) == 0) bus.start = ~bus.start;
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0; bus.collision = 1'b0;
    idle(4);

    chk_en = 1'b0;
    idle(2);
    chk("pending_steps",  32'(step_q.size()), 32'd0);
    chk("pending_cycles", 32'(cyc_q.size()),  32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
